pipe_skid_reg: RTL

Parametrised inter-stage pipeline register with a valid/ready handshake, a two-entry skid buffer and flush-to-NOP squashing. It generalises the fetch/decode boundary register into a reusable stage boundary (IF/ID, ID/EX, …) that tolerates downstream back-pressure without a combinational ready path. On a branch redirect it converts the captured slot into a NOP bubble instead of passing wrong-path instructions.

---
 rtl/pipe_pkg.sv | 15 +
 rtl/pipe_slot.sv | 35 +++
 rtl/pipe_skid_reg.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for pipeline stage-boundary registers: bubble encoding,
// skid-buffer occupancy states and default payload widths.
package pipe_pkg;

    localparam logic [31:0] RV_NOP      = 32'h0000_0013;  // ADDI x0,x0,0
    localparam int          DEF_INSTR_W = 32;
    localparam int          DEF_ADDR_W  = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One payload register entry (instr/addr/bubble) with load enable; carries no
// valid bit, occupancy is tracked by the owning stage.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W     = DEF_INSTR_W,
    parameter int                 ADDR_W      = DEF_ADDR_W,
    parameter logic [INSTR_W-1:0] RESET_INSTR = INSTR_W'(RV_NOP)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               load,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic               load_bubble,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  addr,
    output logic               bubble
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr  <= RESET_INSTR;
            addr   <= '0;
            bubble <= 1'b0;
        end else if (load) begin
            instr  <= load_instr;
            addr   <= load_addr;
            bubble <= load_bubble;
        end
    end

endmodule

// File: rtl/pipe_skid_reg.sv
// Stage-boundary register with valid/ready handshake, two-entry skid buffer and
// flush-to-NOP squashing. Optional PIPE_SKID_STATS_EN adds stall/bubble counters.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int                 INSTR_W = DEF_INSTR_W,
    parameter int                 ADDR_W  = DEF_ADDR_W,
    parameter logic [INSTR_W-1:0] NOP_VAL = INSTR_W'(RV_NOP)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_addr,
    output logic               out_bubble
`ifdef PIPE_SKID_STATS_EN
    ,
    output logic [15:0]        stall_cnt,
    output logic [15:0]        bubble_cnt
`endif
);

    skid_state_e        state_q, state_nxt;
    logic               in_ready_q;
    logic               accept, pop;
    logic               main_load, skid_load;
    logic [INSTR_W-1:0] main_instr_nxt, main_instr, skid_instr;
    logic [ADDR_W-1:0]  main_addr_nxt, main_addr, skid_addr;
    logic               main_bubble_nxt, main_bubble, skid_bubble;

    assign accept = in_valid & in_ready_q;
    assign pop    = out_valid & out_ready;

    // NOTE: every always_comb output gets a default first so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        state_nxt       = state_q;
        main_load       = 1'b0;
        skid_load       = 1'b0;
        main_instr_nxt  = in_instr;
        main_addr_nxt   = in_addr;
        main_bubble_nxt = 1'b0;

        if (flush) begin
            // Wrong-path entries are dropped; a same-cycle arrival becomes a bubble.
            if (accept) begin
                main_load       = 1'b1;
                main_instr_nxt  = NOP_VAL;
                main_bubble_nxt = 1'b1;
                state_nxt       = ONE;
            end else begin
                state_nxt = EMPTY;
            end
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (accept) begin
                        main_load = 1'b1;
                        state_nxt = ONE;
                    end
                end
                ONE: begin
                    if (accept && pop) begin
                        main_load = 1'b1;
                    end else if (accept) begin
                        skid_load = 1'b1;
                        state_nxt = TWO;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (pop) begin
                        main_load       = 1'b1;
                        main_instr_nxt  = skid_instr;
                        main_addr_nxt   = skid_addr;
                        main_bubble_nxt = skid_bubble;
                        state_nxt       = ONE;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // in_ready comes straight from a flop, keeping out_ready off any upstream path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_nxt;
            in_ready_q <= (state_nxt != TWO);
        end
    end

    pipe_slot #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .RESET_INSTR(NOP_VAL)) u_main (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (main_load),
        .load_instr  (main_instr_nxt),
        .load_addr   (main_addr_nxt),
        .load_bubble (main_bubble_nxt),
        .instr       (main_instr),
        .addr        (main_addr),
        .bubble      (main_bubble)
    );

    pipe_slot #(.INSTR_W(INSTR_W), .ADDR_W(ADDR_W), .RESET_INSTR(NOP_VAL)) u_skid (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (skid_load),
        .load_instr  (in_instr),
        .load_addr   (in_addr),
        .load_bubble (1'b0),
        .instr       (skid_instr),
        .addr        (skid_addr),
        .bubble      (skid_bubble)
    );

    assign in_ready   = in_ready_q;
    assign out_valid  = (state_q != EMPTY);
    assign out_instr  = out_valid ? main_instr : NOP_VAL;
    assign out_addr   = main_addr;
    assign out_bubble = out_valid & main_bubble;

`ifdef PIPE_SKID_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else begin
            if (in_valid && !in_ready_q && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (flush && accept && bubble_cnt != 16'hFFFF)
                bubble_cnt <= bubble_cnt + 16'd1;
        end
    end
`endif

endmodule
